// File: rtl/h264_col_pkg.sv
// rtl/h264_col_pkg.sv - shared widths, intra marker, read FSM encoding and field slicing for the co-located store
package h264_col_pkg;

  localparam int NPART_DEF = 4;
  localparam int MV_W_DEF  = 11;
  localparam int REF_W_DEF = 5;

  localparam logic [REF_W_DEF-1:0] REF_INTRA = '1;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_e;

  // Generic slicer: callers cast the bus up to FIELD_BUS_W and the result down to their field width.
  localparam int FIELD_MAX_W = 16;
  localparam int FIELD_BUS_W = 256;

  function automatic logic [FIELD_MAX_W-1:0] field_get(input logic [FIELD_BUS_W-1:0] bus,
                                                       input int p, input int w);
    logic [FIELD_BUS_W-1:0] sh;
    logic [FIELD_MAX_W-1:0] mask;
    sh   = bus >> (p * w);
    mask = (FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1);
    return sh[FIELD_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/col_mv_store_if.sv
// rtl/col_mv_store_if.sv - co-located RAM port bundle; master is the store, slave is the RAM controller
interface col_mv_store_if
  import h264_col_pkg::*;
#(
  parameter int NPART  = NPART_DEF,
  parameter int MV_W   = MV_W_DEF,
  parameter int REF_W  = REF_W_DEF,
  parameter int ADDR_W = 14
);
  logic                     col_wr_n;
  logic                     col_rd_n;
  logic [ADDR_W-1:0]        col_wr_addr;
  logic [ADDR_W-1:0]        col_rd_addr;
  logic [NPART*REF_W-1:0]   col_refidx_din;
  logic [NPART*MV_W-1:0]    col_mvx_din;
  logic [NPART*MV_W-1:0]    col_mvy_din;
  logic [NPART*REF_W-1:0]   col_refidx_dout;
  logic [NPART*MV_W-1:0]    col_mvx_dout;
  logic [NPART*MV_W-1:0]    col_mvy_dout;
  logic                     col_valid;

  modport master (
    output col_wr_n, col_rd_n, col_wr_addr, col_rd_addr,
           col_refidx_din, col_mvx_din, col_mvy_din,
    input  col_refidx_dout, col_mvx_dout, col_mvy_dout, col_valid
  );

  modport slave (
    input  col_wr_n, col_rd_n, col_wr_addr, col_rd_addr,
           col_refidx_din, col_mvx_din, col_mvy_din,
    output col_refidx_dout, col_mvx_dout, col_mvy_dout, col_valid
  );
endinterface

// File: rtl/col_part_sel.sv
// rtl/col_part_sel.sv - one partition: L0/L1/intra field select for storage, and colZeroFlag of fetched motion
module col_part_sel
  import h264_col_pkg::*;
#(
  parameter int MV_W  = MV_W_DEF,
  parameter int REF_W = REF_W_DEF
) (
  input  logic                    intra_i,
  input  logic                    pred_l0_i,
  input  logic [REF_W-1:0]        ref_l0_i,
  input  logic [REF_W-1:0]        ref_l1_i,
  input  logic [MV_W-1:0]         mvx_l0_i,
  input  logic [MV_W-1:0]         mvy_l0_i,
  input  logic [MV_W-1:0]         mvx_l1_i,
  input  logic [MV_W-1:0]         mvy_l1_i,
  output logic [REF_W-1:0]        ref_o,
  output logic [MV_W-1:0]         mvx_o,
  output logic [MV_W-1:0]         mvy_o,
  input  logic [REF_W-1:0]        zf_ref_i,
  input  logic signed [MV_W-1:0]  zf_mvx_i,
  input  logic signed [MV_W-1:0]  zf_mvy_i,
  output logic                    zero_o
);
  localparam logic signed [MV_W-1:0] MV_POS1 = MV_W'(1);
  localparam logic signed [MV_W-1:0] MV_NEG1 = '1;

  always_comb begin
    ref_o = ref_l1_i;
    mvx_o = mvx_l1_i;
    mvy_o = mvy_l1_i;
    if (intra_i) begin
      ref_o = '1;
      mvx_o = '0;
      mvy_o = '0;
    end else if (pred_l0_i) begin
      ref_o = ref_l0_i;
      mvx_o = mvx_l0_i;
      mvy_o = mvy_l0_i;
    end
  end

  // Intra partitions carry an all-ones refIdx, so the refIdx==0 term already forces them to 0.
  assign zero_o = (zf_ref_i == '0) &&
                  (zf_mvx_i >= MV_NEG1) && (zf_mvx_i <= MV_POS1) &&
                  (zf_mvy_i >= MV_NEG1) && (zf_mvy_i <= MV_POS1);

endmodule

// File: rtl/col_mv_store.sv
// rtl/col_mv_store.sv - co-located motion store: writes reference-picture MB motion, fetches co-located MB with write bypass
module col_mv_store
  import h264_col_pkg::*;
#(
  parameter int NPART = NPART_DEF,
  parameter int MV_W  = MV_W_DEF,
  parameter int REF_W = REF_W_DEF,
  parameter int MBX_W = 7,
  parameter int MBY_W = 7,
  localparam int ADDR_W = MBX_W + MBY_W,
  localparam int PI_W   = (NPART > 1) ? $clog2(NPART) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic                     wr_en_ref,
  input  logic [MBX_W-1:0]         wr_mb_x,
  input  logic [MBY_W-1:0]         wr_mb_y,
  input  logic                     wr_intra,
  input  logic [NPART-1:0]         wr_pred_l0,
  input  logic [NPART*REF_W-1:0]   wr_refidx_l0,
  input  logic [NPART*REF_W-1:0]   wr_refidx_l1,
  input  logic [NPART*MV_W-1:0]    wr_mvx_l0,
  input  logic [NPART*MV_W-1:0]    wr_mvy_l0,
  input  logic [NPART*MV_W-1:0]    wr_mvx_l1,
  input  logic [NPART*MV_W-1:0]    wr_mvy_l1,
  input  logic                     rd_req,
  input  logic [MBX_W-1:0]         rd_mb_x,
  input  logic [MBY_W-1:0]         rd_mb_y,
  input  logic [PI_W-1:0]          part_idx,
  output logic                     rd_busy,
  output logic                     rd_done,
  output logic [REF_W-1:0]         refidx_col,
  output logic [MV_W-1:0]          mvx_col,
  output logic [MV_W-1:0]          mvy_col,
  output logic                     col_intra,
  output logic [NPART-1:0]         col_zero_flags,
  col_mv_store_if.master           ram
);
  logic [NPART*REF_W-1:0] sel_ref;
  logic [NPART*MV_W-1:0]  sel_mvx, sel_mvy;
  logic [NPART*REF_W-1:0] src_ref;
  logic [NPART*MV_W-1:0]  src_mvx, src_mvy;
  logic [NPART-1:0]       zf_d, zf_q;

  logic                   wr_n_d, wr_n_q;
  logic [ADDR_W-1:0]      wr_addr_d, wr_addr_q;
  logic [NPART*REF_W-1:0] wr_ref_d, wr_ref_q;
  logic [NPART*MV_W-1:0]  wr_mvx_d, wr_mvx_q, wr_mvy_d, wr_mvy_q;

  rd_state_e              state_d, state_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic                   byp_q;
  logic [NPART*REF_W-1:0] byp_ref_q, cap_ref_q;
  logic [NPART*MV_W-1:0]  byp_mvx_q, byp_mvy_q, cap_mvx_q, cap_mvy_q;
  logic                   byp_hit;

  for (genvar p = 0; p < NPART; p++) begin : g_part
    col_part_sel #(.MV_W(MV_W), .REF_W(REF_W)) u_sel (
      .intra_i   (wr_intra),
      .pred_l0_i (wr_pred_l0[p]),
      .ref_l0_i  (wr_refidx_l0[p*REF_W +: REF_W]),
      .ref_l1_i  (wr_refidx_l1[p*REF_W +: REF_W]),
      .mvx_l0_i  (wr_mvx_l0[p*MV_W +: MV_W]),
      .mvy_l0_i  (wr_mvy_l0[p*MV_W +: MV_W]),
      .mvx_l1_i  (wr_mvx_l1[p*MV_W +: MV_W]),
      .mvy_l1_i  (wr_mvy_l1[p*MV_W +: MV_W]),
      .ref_o     (sel_ref[p*REF_W +: REF_W]),
      .mvx_o     (sel_mvx[p*MV_W +: MV_W]),
      .mvy_o     (sel_mvy[p*MV_W +: MV_W]),
      .zf_ref_i  (src_ref[p*REF_W +: REF_W]),
      .zf_mvx_i  (src_mvx[p*MV_W +: MV_W]),
      .zf_mvy_i  (src_mvy[p*MV_W +: MV_W]),
      .zero_o    (zf_d[p])
    );
  end

  always_comb begin
    wr_n_d    = 1'b1;
    wr_addr_d = '0;
    wr_ref_d  = '0;
    wr_mvx_d  = '0;
    wr_mvy_d  = '0;
    if (wr_req && wr_en_ref) begin
      wr_n_d    = 1'b0;
      wr_addr_d = {wr_mb_x, wr_mb_y};
      wr_ref_d  = sel_ref;
      wr_mvx_d  = sel_mvx;
      wr_mvy_d  = sel_mvy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_n_q    <= 1'b1;
      wr_addr_q <= '0;
      wr_ref_q  <= '0;
      wr_mvx_q  <= '0;
      wr_mvy_q  <= '0;
    end else begin
      wr_n_q    <= wr_n_d;
      wr_addr_q <= wr_addr_d;
      wr_ref_q  <= wr_ref_d;
      wr_mvx_q  <= wr_mvx_d;
      wr_mvy_q  <= wr_mvy_d;
    end
  end

  assign ram.col_wr_n       = wr_n_q;
  assign ram.col_wr_addr    = wr_addr_q;
  assign ram.col_refidx_din = wr_ref_q;
  assign ram.col_mvx_din    = wr_mvx_q;
  assign ram.col_mvy_din    = wr_mvy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:  if (rd_req) state_d = RD_ISSUE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (ram.col_valid) state_d = RD_DONE;
      RD_DONE:  state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_busy         = (state_q != RD_IDLE);
    rd_done         = (state_q == RD_DONE);
    ram.col_rd_n    = (state_q != RD_ISSUE);
    ram.col_rd_addr = (state_q == RD_ISSUE) ? rd_addr_q : '0;
  end

  // A write landing in the same cycle as col_valid is newer than anything buffered, so it wins.
  assign byp_hit = ((state_q == RD_ISSUE) || (state_q == RD_WAIT)) &&
                   !wr_n_q && (wr_addr_q == rd_addr_q);

  always_comb begin
    src_ref = ram.col_refidx_dout;
    src_mvx = ram.col_mvx_dout;
    src_mvy = ram.col_mvy_dout;
    if (byp_hit) begin
      src_ref = wr_ref_q;
      src_mvx = wr_mvx_q;
      src_mvy = wr_mvy_q;
    end else if (byp_q) begin
      src_ref = byp_ref_q;
      src_mvx = byp_mvx_q;
      src_mvy = byp_mvy_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      byp_q     <= 1'b0;
      byp_ref_q <= '0;
      byp_mvx_q <= '0;
      byp_mvy_q <= '0;
      cap_ref_q <= '0;
      cap_mvx_q <= '0;
      cap_mvy_q <= '0;
      zf_q      <= '0;
    end else begin
      if ((state_q == RD_IDLE) && rd_req) rd_addr_q <= {rd_mb_x, rd_mb_y};
      if (state_q == RD_IDLE) begin
        byp_q <= 1'b0;
      end else if (byp_hit) begin
        byp_q     <= 1'b1;
        byp_ref_q <= wr_ref_q;
        byp_mvx_q <= wr_mvx_q;
        byp_mvy_q <= wr_mvy_q;
      end
      if ((state_q == RD_WAIT) && ram.col_valid) begin
        cap_ref_q <= src_ref;
        cap_mvx_q <= src_mvx;
        cap_mvy_q <= src_mvy;
        zf_q      <= zf_d;
      end
    end
  end

  assign col_zero_flags = zf_q;
  assign refidx_col = REF_W'(field_get(FIELD_BUS_W'(cap_ref_q), int'(part_idx), REF_W));
  assign mvx_col    = MV_W'(field_get(FIELD_BUS_W'(cap_mvx_q), int'(part_idx), MV_W));
  assign mvy_col    = MV_W'(field_get(FIELD_BUS_W'(cap_mvy_q), int'(part_idx), MV_W));
  assign col_intra  = &refidx_col;

endmodule

// File: tb/tb_col_mv_store.sv
// tb/tb_col_mv_store.sv - directed self-checking bench for col_mv_store
module tb_col_mv_store;
  import h264_col_pkg::*;

  localparam int NP = 4;
  localparam int MW = 11;
  localparam int RW = 5;
  localparam int XW = 7;
  localparam int YW = 7;
  localparam int AW = XW + YW;

  localparam logic [MW-1:0] MV_N1  = 11'h7FF;
  localparam logic [MW-1:0] MV_N3  = 11'h7FD;
  localparam logic [MW-1:0] MV_N20 = 11'h7EC;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_req, wr_en_ref, wr_intra, rd_req;
  logic [XW-1:0]     wr_mb_x, rd_mb_x;
  logic [YW-1:0]     wr_mb_y, rd_mb_y;
  logic [NP-1:0]     wr_pred_l0;
  logic [NP*RW-1:0]  wr_refidx_l0, wr_refidx_l1;
  logic [NP*MW-1:0]  wr_mvx_l0, wr_mvy_l0, wr_mvx_l1, wr_mvy_l1;
  logic [1:0]        part_idx;
  logic              rd_busy, rd_done, col_intra;
  logic [RW-1:0]     refidx_col;
  logic [MW-1:0]     mvx_col, mvy_col;
  logic [NP-1:0]     col_zero_flags;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  col_mv_store_if #(.NPART(NP), .MV_W(MW), .REF_W(RW), .ADDR_W(AW)) ram_if ();

  col_mv_store #(.NPART(NP), .MV_W(MW), .REF_W(RW), .MBX_W(XW), .MBY_W(YW)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_en_ref(wr_en_ref), .wr_mb_x(wr_mb_x), .wr_mb_y(wr_mb_y),
    .wr_intra(wr_intra), .wr_pred_l0(wr_pred_l0),
    .wr_refidx_l0(wr_refidx_l0), .wr_refidx_l1(wr_refidx_l1),
    .wr_mvx_l0(wr_mvx_l0), .wr_mvy_l0(wr_mvy_l0), .wr_mvx_l1(wr_mvx_l1), .wr_mvy_l1(wr_mvy_l1),
    .rd_req(rd_req), .rd_mb_x(rd_mb_x), .rd_mb_y(rd_mb_y), .part_idx(part_idx),
    .rd_busy(rd_busy), .rd_done(rd_done), .refidx_col(refidx_col),
    .mvx_col(mvx_col), .mvy_col(mvy_col), .col_intra(col_intra),
    .col_zero_flags(col_zero_flags), .ram(ram_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*RW-1:0] rep_ref(input logic [RW-1:0] r);
    return {NP{r}};
  endfunction

  function automatic logic [NP*MW-1:0] rep_mv(input logic [MW-1:0] v);
    return {NP{v}};
  endfunction

  // RAM answers the cycle after the ISSUE strobe; rd_done is due one cycle later.
  task automatic ram_read(input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [NP*RW-1:0] r, input logic [NP*MW-1:0] mx,
                          input logic [NP*MW-1:0] my, input string tag);
    rd_mb_x = x; rd_mb_y = y; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check({tag, "_rd_n"}, 64'(ram_if.col_rd_n), 64'(1'b0));
    check({tag, "_rd_addr"}, 64'(ram_if.col_rd_addr), 64'({x, y}));
    tick();
    ram_if.col_refidx_dout = r; ram_if.col_mvx_dout = mx; ram_if.col_mvy_dout = my;
    ram_if.col_valid = 1'b1;
    tick();
    ram_if.col_valid = 1'b0;
    check({tag, "_rd_done"}, 64'(rd_done), 64'(1'b1));
  endtask

  initial begin
    wr_req = 0; wr_en_ref = 1; wr_intra = 0; rd_req = 0;
    wr_mb_x = '0; wr_mb_y = '0; rd_mb_x = '0; rd_mb_y = '0;
    wr_pred_l0 = '0; wr_refidx_l0 = '0; wr_refidx_l1 = '0;
    wr_mvx_l0 = '0; wr_mvy_l0 = '0; wr_mvx_l1 = '0; wr_mvy_l1 = '0;
    part_idx = '0;
    ram_if.col_valid = 1'b0; ram_if.col_refidx_dout = '0;
    ram_if.col_mvx_dout = '0; ram_if.col_mvy_dout = '0;

    repeat (2) tick();
    check("rst_wr_n", 64'(ram_if.col_wr_n), 64'(1'b1));
    check("rst_rd_n", 64'(ram_if.col_rd_n), 64'(1'b1));
    check("rst_busy", 64'(rd_busy), 64'(1'b0));
    check("rst_done", 64'(rd_done), 64'(1'b0));
    check("rst_wr_addr", 64'(ram_if.col_wr_addr), 64'(0));
    check("rst_rd_addr", 64'(ram_if.col_rd_addr), 64'(0));
    check("rst_din", 64'(ram_if.col_mvx_din), 64'(0));
    check("rst_ref", 64'(refidx_col), 64'(0));
    check("rst_zf", 64'(col_zero_flags), 64'(0));
    reset = 1'b0;
    tick();

    // Plain L0 write at {3,5}
    wr_mb_x = 7'd3; wr_mb_y = 7'd5; wr_pred_l0 = 4'hF;
    wr_refidx_l0 = rep_ref(5'd0); wr_mvx_l0 = rep_mv(11'd1); wr_mvy_l0 = rep_mv(MV_N1);
    wr_refidx_l1 = rep_ref(5'd9); wr_mvx_l1 = rep_mv(11'd100); wr_mvy_l1 = rep_mv(11'd100);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("w1_wr_n", 64'(ram_if.col_wr_n), 64'(1'b0));
    check("w1_addr", 64'(ram_if.col_wr_addr), 64'(14'h0185));
    check("w1_ref", 64'(ram_if.col_refidx_din), 64'(rep_ref(5'd0)));
    check("w1_mvx", 64'(ram_if.col_mvx_din), 64'(rep_mv(11'd1)));
    check("w1_mvy", 64'(ram_if.col_mvy_din), 64'(rep_mv(MV_N1)));
    tick();
    check("w1_wr_n_off", 64'(ram_if.col_wr_n), 64'(1'b1));
    check("w1_din_off", 64'(ram_if.col_mvy_din), 64'(0));

    // Non-reference picture: no strobe
    wr_en_ref = 1'b0; wr_req = 1'b1;
    tick();
    wr_req = 1'b0; wr_en_ref = 1'b1;
    check("noref_wr_n", 64'(ram_if.col_wr_n), 64'(1'b1));
    check("noref_addr", 64'(ram_if.col_wr_addr), 64'(0));

    // Intra write, then a read of the intra data
    wr_intra = 1'b1; wr_mb_x = 7'd4; wr_mb_y = 7'd4; wr_req = 1'b1;
    tick();
    wr_req = 1'b0; wr_intra = 1'b0;
    check("intra_wr_n", 64'(ram_if.col_wr_n), 64'(1'b0));
    check("intra_ref", 64'(ram_if.col_refidx_din), 64'(rep_ref(REF_INTRA)));
    check("intra_mvx", 64'(ram_if.col_mvx_din), 64'(0));
    check("intra_mvy", 64'(ram_if.col_mvy_din), 64'(0));
    tick();
    ram_read(7'd4, 7'd4, 20'hFFFFF, '0, '0, "intra_rd");
    check("intra_col_intra", 64'(col_intra), 64'(1'b1));
    check("intra_zf", 64'(col_zero_flags), 64'(4'b0000));
    check("intra_refcol", 64'(refidx_col), 64'(5'h1F));
    tick();

    // Mixed L0/L1 partitions
    wr_pred_l0 = 4'b0101; wr_mb_x = 7'd6; wr_mb_y = 7'd1;
    wr_refidx_l0 = rep_ref(5'd1); wr_mvx_l0 = rep_mv(11'd5); wr_mvy_l0 = rep_mv(11'd5);
    wr_refidx_l1 = rep_ref(5'd2); wr_mvx_l1 = rep_mv(11'd7); wr_mvy_l1 = rep_mv(MV_N3);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("mix_ref", 64'(ram_if.col_refidx_din), 64'({5'd2, 5'd1, 5'd2, 5'd1}));
    check("mix_mvx", 64'(ram_if.col_mvx_din), 64'({11'd7, 11'd5, 11'd7, 11'd5}));
    check("mix_mvy", 64'(ram_if.col_mvy_din), 64'({MV_N3, 11'd5, MV_N3, 11'd5}));
    tick();
    ram_read(7'd6, 7'd1, {5'd2, 5'd1, 5'd2, 5'd1}, {11'd7, 11'd5, 11'd7, 11'd5},
             {MV_N3, 11'd5, MV_N3, 11'd5}, "mix_rd");
    part_idx = 2'd1; #1;
    check("mix_p1_ref", 64'(refidx_col), 64'(5'd2));
    check("mix_p1_mvx", 64'(mvx_col), 64'(11'd7));
    check("mix_p1_mvy", 64'(mvy_col), 64'(MV_N3));
    check("mix_p1_intra", 64'(col_intra), 64'(1'b0));
    part_idx = 2'd0; #1;
    check("mix_p0_mvx", 64'(mvx_col), 64'(11'd5));
    check("mix_zf", 64'(col_zero_flags), 64'(4'b0000));
    tick();

    // Slow RAM: col_valid four cycles after ISSUE, stray rd_req in WAIT
    rd_mb_x = 7'd1; rd_mb_y = 7'd1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("lat_issue_rd_n", 64'(ram_if.col_rd_n), 64'(1'b0));
    check("lat_issue_addr", 64'(ram_if.col_rd_addr), 64'(14'h0081));
    check("lat_issue_busy", 64'(rd_busy), 64'(1'b1));
    tick();
    check("lat_wait_rd_n", 64'(ram_if.col_rd_n), 64'(1'b1));
    check("lat_wait_addr", 64'(ram_if.col_rd_addr), 64'(0));
    rd_mb_x = 7'd9; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("lat_w2_done", 64'(rd_done), 64'(1'b0));
    check("lat_w2_rd_n", 64'(ram_if.col_rd_n), 64'(1'b1));
    tick();
    check("lat_w3_done", 64'(rd_done), 64'(1'b0));
    tick();
    check("lat_w4_done", 64'(rd_done), 64'(1'b0));
    check("lat_w4_busy", 64'(rd_busy), 64'(1'b1));
    ram_if.col_refidx_dout = {5'd3, 5'd0, 5'd1, 5'd0};
    ram_if.col_mvx_dout    = {11'd0, 11'd2, 11'd0, 11'd0};
    ram_if.col_mvy_dout    = {11'd0, 11'd0, 11'd0, 11'd1};
    ram_if.col_valid = 1'b1;
    tick();
    ram_if.col_valid = 1'b0;
    check("lat_done", 64'(rd_done), 64'(1'b1));
    check("lat_zf", 64'(col_zero_flags), 64'(4'b0001));
    check("lat_p0_mvy", 64'(mvy_col), 64'(11'd1));
    tick();
    check("lat_done_off", 64'(rd_done), 64'(1'b0));
    check("lat_idle_busy", 64'(rd_busy), 64'(1'b0));
    check("lat_idle_rd_n", 64'(ram_if.col_rd_n), 64'(1'b1));
    check("lat_hold_mvy", 64'(mvy_col), 64'(11'd1));

    // Same-cycle write and read to {2,2}; RAM returns stale data
    wr_pred_l0 = 4'hF; wr_mb_x = 7'd2; wr_mb_y = 7'd2;
    wr_refidx_l0 = rep_ref(5'd3); wr_mvx_l0 = rep_mv(11'd10); wr_mvy_l0 = rep_mv(MV_N20);
    rd_mb_x = 7'd2; rd_mb_y = 7'd2;
    wr_req = 1'b1; rd_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    check("byp_wr_n", 64'(ram_if.col_wr_n), 64'(1'b0));
    check("byp_rd_n", 64'(ram_if.col_rd_n), 64'(1'b0));
    tick();
    ram_if.col_refidx_dout = rep_ref(5'd7);
    ram_if.col_mvx_dout = rep_mv(11'd99); ram_if.col_mvy_dout = rep_mv(11'd99);
    ram_if.col_valid = 1'b1;
    tick();
    ram_if.col_valid = 1'b0;
    check("byp_done", 64'(rd_done), 64'(1'b1));
    check("byp_ref", 64'(refidx_col), 64'(5'd3));
    check("byp_mvx", 64'(mvx_col), 64'(11'd10));
    check("byp_mvy", 64'(mvy_col), 64'(MV_N20));
    part_idx = 2'd3; #1;
    check("byp_p3_ref", 64'(refidx_col), 64'(5'd3));
    check("byp_zf", 64'(col_zero_flags), 64'(4'b0000));
    part_idx = 2'd0;
    tick();

    // Reset while waiting for RAM data
    rd_mb_x = 7'd5; rd_mb_y = 7'd5; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("mrst_pre_busy", 64'(rd_busy), 64'(1'b1));
    reset = 1'b1;
    #1;
    check("mrst_busy", 64'(rd_busy), 64'(1'b0));
    check("mrst_rd_n", 64'(ram_if.col_rd_n), 64'(1'b1));
    check("mrst_wr_n", 64'(ram_if.col_wr_n), 64'(1'b1));
    check("mrst_done", 64'(rd_done), 64'(1'b0));
    check("mrst_ref", 64'(refidx_col), 64'(0));
    check("mrst_mvx", 64'(mvx_col), 64'(0));
    tick();
    reset = 1'b0;
    ram_if.col_valid = 1'b1;
    tick();
    ram_if.col_valid = 1'b0;
    check("mrst_done_a", 64'(rd_done), 64'(1'b0));
    tick();
    check("mrst_done_b", 64'(rd_done), 64'(1'b0));
    check("mrst_busy_b", 64'(rd_busy), 64'(1'b0));
    ram_read(7'd5, 7'd5, rep_ref(5'd0), rep_mv(11'd1), rep_mv(11'd0), "fresh_rd");
    check("fresh_zf", 64'(col_zero_flags), 64'(4'b1111));
    check("fresh_mvx", 64'(mvx_col), 64'(11'd1));
    tick();
    check("fresh_idle", 64'(rd_busy), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
